// File: rtl/rm_link_ctrl_pkg.sv
// Shared sizing, types and controller state encoding for the response-memory link controller.
package rm_link_ctrl_pkg;
  localparam int ID_WIDTH = 4;
  localparam int NUM_UIDS = 2 ** ID_WIDTH;
  localparam int DEPTH    = 32;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);

  typedef logic [ID_WIDTH-1:0] uid_t;
  typedef logic [PTR_W-1:0]    slot_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rm_ctrl_state_e;
endpackage

// File: rtl/rm_link_ctrl_if.sv
// Store/release handshakes, data-array addressing and status of the link controller.
interface rm_link_ctrl_if;
  import rm_link_ctrl_pkg::*;

  logic                st_valid;
  logic                st_ready;
  uid_t                st_uid;
  logic                rel_ready;
  uid_t                rel_uid;
  logic                rel_valid;
  logic                wr_en;
  slot_t               wr_addr;
  slot_t               rd_addr;
  logic [NUM_UIDS-1:0] uid_pending;
  cnt_t                used_cnt;
  logic                init_done;

  modport master (
    output st_valid, st_uid, rel_ready, rel_uid,
    input  st_ready, rel_valid, wr_en, wr_addr, rd_addr, uid_pending, used_cnt, init_done
  );

  modport slave (
    input  st_valid, st_uid, rel_ready, rel_uid,
    output st_ready, rel_valid, wr_en, wr_addr, rd_addr, uid_pending, used_cnt, init_done
  );
endinterface

// File: rtl/rm_link_ctrl_chk.sv
// Invariants of the link controller: no pop from an empty free list, no release of an empty list, counts agree.
module rm_link_ctrl_chk
  import rm_link_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic st_fire,
  input logic rel_fire,
  input cnt_t free_cnt,
  input cnt_t rel_cnt,
  input cnt_t cnt_sum,
  input cnt_t used_cnt
);
  a_store_has_slot: assert property (@(posedge clk) disable iff (rst) st_fire |-> free_cnt != '0);
  a_release_nonempty: assert property (@(posedge clk) disable iff (rst) rel_fire |-> rel_cnt != '0);
  a_count_sum: assert property (@(posedge clk) disable iff (rst) cnt_sum == used_cnt);
endmodule

// File: rtl/rm_link_ctrl_free_list.sv
// Free-slot FIFO: self-initialises to slots 0..DEPTH-1 after reset, then serves pops and accepts pushes.
module rm_free_list
  import rm_link_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  slot_t push_slot,
  input  logic  pop,
  output slot_t pop_slot,
  output cnt_t  free_cnt,
  output logic  running,
  output logic  init_done
);
  rm_ctrl_state_e state_r, state_s;
  slot_t          init_idx_r;
  slot_t          rd_ptr_r;
  slot_t          wr_ptr_r;
  cnt_t           free_cnt_r;
  slot_t          fifo_r [DEPTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= INIT;
    else     state_r <= state_s;
  end

  // Next state: INIT walks every slot once, RUN holds until reset
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (init_idx_r == slot_t'(DEPTH - 1)) state_s = RUN;
        else                                  state_s = INIT;
      end
      RUN:     state_s = RUN;
      default: state_s = INIT;
    endcase
  end

  // Init index, FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx_r <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      free_cnt_r <= '0;
    end else if (state_r == INIT) begin
      init_idx_r <= init_idx_r + slot_t'(1);
      if (init_idx_r == slot_t'(DEPTH - 1)) free_cnt_r <= cnt_t'(DEPTH);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + slot_t'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + slot_t'(1);
      free_cnt_r <= free_cnt_r + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Slot storage; the FIFO is full after init, so wr_ptr has wrapped back to 0
  always_ff @(posedge clk) begin
    if (state_r == INIT) fifo_r[init_idx_r] <= init_idx_r;
    else if (push)       fifo_r[wr_ptr_r]   <= push_slot;
  end

  assign pop_slot  = fifo_r[rd_ptr_r];
  assign free_cnt  = free_cnt_r;
  assign running   = (state_r == RUN);
  assign init_done = running;
endmodule

// File: rtl/rm_link_ctrl.sv
// Response-memory link controller: per-uid linked lists over shared beat slots, released in arrival order.
module rm_link_ctrl
  import rm_link_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rm_link_ctrl_if.slave bus
);
  slot_t               head_r [NUM_UIDS];
  slot_t               tail_r [NUM_UIDS];
  cnt_t                cnt_r  [NUM_UIDS];
  slot_t               nxt_r  [DEPTH];
  cnt_t                used_cnt_r;

  logic                running_s;
  logic                init_done_s;
  cnt_t                free_cnt_s;
  slot_t               pop_slot_s;
  cnt_t                rel_cnt_s;
  cnt_t                st_cnt_s;
  slot_t               rel_head_s;
  logic                st_ready_s;
  logic                rel_valid_s;
  logic                st_fire_s;
  logic                rel_fire_s;
  slot_t               rd_addr_s;
  logic [NUM_UIDS-1:0] inc_s;
  logic [NUM_UIDS-1:0] dec_s;
  logic [NUM_UIDS-1:0] pending_s;
  cnt_t                cnt_sum_s;

  rm_free_list u_free_list (
    .clk       (clk),
    .rst       (rst),
    .push      (rel_fire_s),
    .push_slot (rel_head_s),
    .pop       (st_fire_s),
    .pop_slot  (pop_slot_s),
    .free_cnt  (free_cnt_s),
    .running   (running_s),
    .init_done (init_done_s)
  );

  // Handshakes; readiness never looks at the partner's valid/ready
  always_comb begin
    rel_cnt_s   = cnt_r[bus.rel_uid];
    st_cnt_s    = cnt_r[bus.st_uid];
    rel_head_s  = head_r[bus.rel_uid];
    st_ready_s  = running_s && (free_cnt_s != '0);
    rel_valid_s = running_s && (rel_cnt_s != '0);
    st_fire_s   = bus.st_valid && st_ready_s;
    rel_fire_s  = bus.rel_ready && rel_valid_s;
    if (rel_valid_s) rd_addr_s = rel_head_s;
    else             rd_addr_s = '0;
  end

  // One-hot per-uid increment/decrement strobes
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    if (st_fire_s)  inc_s[bus.st_uid]  = 1'b1;
    else            inc_s              = '0;
    if (rel_fire_s) dec_s[bus.rel_uid] = 1'b1;
    else            dec_s              = '0;
  end

  // Per-uid list heads, tails and beat counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        head_r[u] <= '0;
        tail_r[u] <= '0;
        cnt_r[u]  <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        if (inc_s[u]) tail_r[u] <= pop_slot_s;
        // The new slot becomes head when the list is (or is about to be) empty
        if (inc_s[u] && (cnt_r[u] == cnt_t'(dec_s[u]))) head_r[u] <= pop_slot_s;
        else if (dec_s[u])                               head_r[u] <= nxt_r[head_r[u]];
        cnt_r[u] <= cnt_r[u] + cnt_t'(inc_s[u]) - cnt_t'(dec_s[u]);
      end
    end
  end

  // Link the stored slot behind the current tail
  always_ff @(posedge clk) begin
    if (st_fire_s && (st_cnt_s != '0)) nxt_r[tail_r[bus.st_uid]] <= pop_slot_s;
  end

  // Occupancy tracks DEPTH-free_cnt in the same cycle as the free list
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             used_cnt_r <= '0;
    else if (!running_s) used_cnt_r <= '0;
    else                 used_cnt_r <= used_cnt_r + cnt_t'(st_fire_s) - cnt_t'(rel_fire_s);
  end

  // Pending flags and total count across all lists
  always_comb begin
    pending_s = '0;
    cnt_sum_s = '0;
    for (int u = 0; u < NUM_UIDS; u++) begin
      pending_s[u] = (cnt_r[u] != '0);
      cnt_sum_s    = cnt_sum_s + cnt_r[u];
    end
  end

  assign bus.st_ready    = st_ready_s;
  assign bus.rel_valid   = rel_valid_s;
  assign bus.wr_en       = st_fire_s;
  assign bus.wr_addr     = pop_slot_s;
  assign bus.rd_addr     = rd_addr_s;
  assign bus.uid_pending = pending_s;
  assign bus.used_cnt    = used_cnt_r;
  assign bus.init_done   = init_done_s;

  rm_link_ctrl_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .st_fire  (st_fire_s),
    .rel_fire (rel_fire_s),
    .free_cnt (free_cnt_s),
    .rel_cnt  (rel_cnt_s),
    .cnt_sum  (cnt_sum_s),
    .used_cnt (used_cnt_r)
  );
endmodule

// File: tb/tb_rm_link_ctrl.sv
// Directed bench for rm_link_ctrl: init timing, in-order release, interleaving, full list, same-cycle ops, reset.
module tb_rm_link_ctrl;
  import rm_link_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rm_link_ctrl_if bus ();

  rm_link_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(bus.init_done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.st_valid  = 1'b0;
    bus.rel_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("reinit");
  endtask

  // Entered and left 1 time unit after a rising edge
  task automatic store(input logic [3:0] uid, input int exp);
    bus.st_uid   = uid;
    bus.st_valid = 1'b1;
    #1;
    chk("st_ready", 32'(bus.st_ready), 32'd1);
    chk("wr_en", 32'(bus.wr_en), 32'd1);
    chk("wr_addr", 32'(bus.wr_addr), 32'(exp));
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
  endtask

  task automatic release_beat(input logic [3:0] uid, input int exp);
    bus.rel_uid   = uid;
    bus.rel_ready = 1'b1;
    #1;
    chk("rel_valid", 32'(bus.rel_valid), 32'd1);
    chk("rd_addr", 32'(bus.rd_addr), 32'(exp));
    @(posedge clk); #1;
    bus.rel_ready = 1'b0;
  endtask

  initial begin
    bus.st_valid  = 1'b0;
    bus.st_uid    = 4'd0;
    bus.rel_ready = 1'b0;
    bus.rel_uid   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(bus.st_ready), 32'd0);
    chk("rst_rel_valid", 32'(bus.rel_valid), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_pending", 32'(bus.uid_pending), 32'd0);
    chk("rst_used", 32'(bus.used_cnt), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);

    // Init takes exactly DEPTH edges after reset release
    rst = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    chk("init_31_done", 32'(bus.init_done), 32'd0);
    chk("init_31_ready", 32'(bus.st_ready), 32'd0);
    @(posedge clk); #1;
    chk("init_32_done", 32'(bus.init_done), 32'd1);
    chk("init_32_ready", 32'(bus.st_ready), 32'd1);
    chk("init_32_rel_valid", 32'(bus.rel_valid), 32'd0);

    // Single uid, in-order release
    store(4'd5, 0);
    store(4'd5, 1);
    store(4'd5, 2);
    chk("u5_pending", 32'(bus.uid_pending), 32'h0000_0020);
    chk("u5_used", 32'(bus.used_cnt), 32'd3);
    release_beat(4'd5, 0);
    release_beat(4'd5, 1);
    release_beat(4'd5, 2);
    chk("u5_pending_clr", 32'(bus.uid_pending), 32'd0);
    chk("u5_used_clr", 32'(bus.used_cnt), 32'd0);
    chk("u5_rel_valid_clr", 32'(bus.rel_valid), 32'd0);

    // Interleaved uids
    do_reset();
    store(4'd3, 0);
    store(4'd7, 1);
    store(4'd3, 2);
    store(4'd7, 3);
    chk("il_used4", 32'(bus.used_cnt), 32'd4);
    chk("il_pending", 32'(bus.uid_pending), 32'h0000_0088);
    release_beat(4'd7, 1);
    release_beat(4'd7, 3);
    release_beat(4'd3, 0);
    release_beat(4'd3, 2);
    chk("il_used0", 32'(bus.used_cnt), 32'd0);

    // Fill every slot on uid 0
    do_reset();
    for (int i = 0; i < 32; i++) store(4'd0, i);
    chk("full_used", 32'(bus.used_cnt), 32'd32);
    bus.st_valid = 1'b1;
    #1;
    chk("full_st_ready", 32'(bus.st_ready), 32'd0);
    chk("full_wr_en", 32'(bus.wr_en), 32'd0);
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    chk("full_used_hold", 32'(bus.used_cnt), 32'd32);
    release_beat(4'd0, 0);
    chk("full_ready_back", 32'(bus.st_ready), 32'd1);
    chk("full_used31", 32'(bus.used_cnt), 32'd31);
    store(4'd0, 0);
    release_beat(4'd0, 1);

    // Same-cycle store and release on a one-beat list
    do_reset();
    for (int i = 0; i < 4; i++) store(4'd1, i);
    store(4'd9, 4);
    bus.st_uid    = 4'd9;
    bus.st_valid  = 1'b1;
    bus.rel_uid   = 4'd9;
    bus.rel_ready = 1'b1;
    #1;
    chk("same_wr_addr", 32'(bus.wr_addr), 32'd5);
    chk("same_rd_addr", 32'(bus.rd_addr), 32'd4);
    chk("same_rel_valid", 32'(bus.rel_valid), 32'd1);
    @(posedge clk); #1;
    bus.st_valid  = 1'b0;
    bus.rel_ready = 1'b0;
    chk("same_pending9", 32'(bus.uid_pending[9]), 32'd1);
    chk("same_used", 32'(bus.used_cnt), 32'd5);
    release_beat(4'd9, 5);
    chk("same_u9_empty", 32'(bus.rel_valid), 32'd0);
    chk("same_used4", 32'(bus.used_cnt), 32'd4);

    // Reset while holding ten beats
    for (int i = 0; i < 6; i++) store(4'd2, 6 + i);
    chk("hold_used10", 32'(bus.used_cnt), 32'd10);
    bus.st_uid   = 4'd2;
    bus.st_valid = 1'b1;
    bus.rel_uid  = 4'd1;
    rst = 1'b1;
    #1;
    chk("mid_st_ready", 32'(bus.st_ready), 32'd0);
    chk("mid_wr_en", 32'(bus.wr_en), 32'd0);
    chk("mid_rel_valid", 32'(bus.rel_valid), 32'd0);
    chk("mid_pending", 32'(bus.uid_pending), 32'd0);
    chk("mid_used", 32'(bus.used_cnt), 32'd0);
    chk("mid_init_done", 32'(bus.init_done), 32'd0);
    bus.st_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("mid_reinit");
    chk("post_pending", 32'(bus.uid_pending), 32'd0);
    chk("post_used", 32'(bus.used_cnt), 32'd0);
    chk("post_rel_valid", 32'(bus.rel_valid), 32'd0);
    store(4'd1, 0);
    chk("post_pending1", 32'(bus.uid_pending), 32'h0000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
